// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM encoding, reset
// address default and the instruction field layout used by target math.
package mips_pkg;

    // Fetch sequencer states. At most one memory request is ever in flight.
    //   ST_IDLE  : single settling cycle after reset release
    //   ST_FETCH : request on the bus (imem_req=1, imem_addr=pc)
    //   ST_WAIT  : waiting for the response to the live request
    //   ST_HOLD  : instruction presented downstream (inst_valid=1)
    //   ST_DROP  : a redirect orphaned the live request; swallow its response
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DROP  = 3'd4
    } fetch_state_e;

    // First fetch address after reset unless the instance overrides it.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Sequential instruction stride in bytes.
    localparam logic [31:0] INST_BYTES = 32'd4;

    // J-type opcode.
    localparam logic [5:0] OPCODE_J = 6'b000010;

    // Instruction field positions.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    // Extract the primary opcode of an instruction word.
    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational redirect logic: decides whether the resolving control-flow
// instruction is taken and computes where fetch must go next.
module branch_target_calc
    import mips_pkg::*;
(
    input  logic        resolve_valid,
    input  logic [31:0] resolve_pc,
    input  logic [31:0] resolve_inst,
    input  logic        branch_eq,
    input  logic        branch_neq,
    input  logic        jump,
    input  logic        zero,
    output logic        taken,
    output logic [31:0] target
);

    logic [31:0] pc_plus4;
    logic [31:0] imm_ext;
    logic [31:0] jump_target;
    logic [31:0] branch_target;

    // The decoder's Jump flag is authoritative; the raw opcode is not
    // re-decoded here, so its bits are only folded into a sink.
    logic unused_opcode;
    assign unused_opcode = (opcode_of(resolve_inst) == OPCODE_J);

    // Target arithmetic and the taken decision; jump outranks any branch.
    always_comb begin
        pc_plus4      = resolve_pc + INST_BYTES;
        imm_ext       = {{16{resolve_inst[IMM_MSB]}}, resolve_inst[IMM_MSB:IMM_LSB]};
        jump_target   = {pc_plus4[31:28], resolve_inst[TARGET_MSB:TARGET_LSB], 2'b00};
        branch_target = pc_plus4 + (imm_ext << 2);
        taken         = resolve_valid &
                        (jump | (branch_eq & zero) | (branch_neq & ~zero));
        target        = jump ? jump_target : branch_target;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: walks the PC through a single-outstanding-request
// memory port, presents each word downstream, and redirects on taken
// branches/jumps, discarding any response that belongs to the old path.
//
// Downstream handshake: inst/inst_pc are live while inst_valid=1 and stay
// stable until the cycle where inst_valid & inst_ready are both high at a
// rising clk edge; that edge transfers the instruction. A taken redirect in
// the same cycle wins, and the instruction is discarded instead.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_valid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  inst,
    output logic [31:0]  inst_pc,
    output logic         inst_valid,
    input  logic         inst_ready,
    input  logic         resolve_valid,
    input  logic [31:0]  resolve_pc,
    input  logic [31:0]  resolve_inst,
    input  logic         BranchEq,
    input  logic         BranchNeq,
    input  logic         Jump,
    input  logic         Zero,
    output fetch_state_e state
);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic [31:0]  pc_q;
    logic [31:0]  pc_d;
    logic [31:0]  inst_d;
    logic [31:0]  inst_pc_d;
    logic         taken;
    logic [31:0]  target;

    branch_target_calc u_target (
        .resolve_valid (resolve_valid),
        .resolve_pc    (resolve_pc),
        .resolve_inst  (resolve_inst),
        .branch_eq     (BranchEq),
        .branch_neq    (BranchNeq),
        .jump          (Jump),
        .zero          (Zero),
        .taken         (taken),
        .target        (target)
    );

    assign state = state_q;

    // State, PC and the presented instruction register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            inst    <= 32'h0;
            inst_pc <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst    <= inst_d;
            inst_pc <= inst_pc_d;
        end
    end

    // Next-state logic; a taken redirect overrides capture, handshake and issue.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst;
        inst_pc_d = inst_pc;
        case (state_q)
            ST_IDLE: begin
                // Any response still arriving from before reset is ignored.
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (taken) begin
                    // The request is already on the bus; its answer is stale.
                    pc_d    = target;
                    state_d = ST_DROP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (taken) begin
                    pc_d    = target;
                    state_d = imem_valid ? ST_FETCH : ST_DROP;
                end else if (imem_valid) begin
                    inst_d    = imem_rdata;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + INST_BYTES;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (taken) begin
                    pc_d    = target;
                    state_d = ST_FETCH;
                end else if (inst_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DROP: begin
                // A further redirect only retargets; still owe one response.
                if (taken) begin
                    pc_d = target;
                end
                if (imem_valid) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded purely from state so they are glitch-free per cycle.
    always_comb begin
        imem_req   = 1'b0;
        imem_addr  = 32'h0;
        inst_valid = 1'b0;
        if (state_q == ST_FETCH) begin
            imem_req  = 1'b1;
            imem_addr = pc_q;
        end
        if (state_q == ST_HOLD) begin
            inst_valid = 1'b1;
        end
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 imem_req  output  1  one-cycle instruction memory read request pulse.
REQ-006 imem_addr  output  32  byte address of the request; valid while imem_req=1.
REQ-007 imem_valid  input  1  response strobe, one cycle, at least 1 cycle after imem_req.
REQ-008 imem_rdata  input  32  instruction word; valid with imem_valid.
REQ-009 inst  output  32  fetched instruction; bits [31:26] drive the opcode decoder.
REQ-010 inst_pc  output  32  address of inst.
REQ-011 inst_valid  output  1  inst/inst_pc hold a live instruction.
REQ-012 inst_ready  input  1  downstream accepts inst this cycle.
REQ-013 resolve_valid  input  1  a control-flow instruction is resolving this cycle.
REQ-014 resolve_pc, resolve_inst  input  32 each  address and word of the resolving instruction.
REQ-015 BranchEq, BranchNeq, Jump  input  1 each  decoder control outputs for the resolving instruction.
REQ-016 Zero  input  1  ALU equality result for the resolving instruction.

Function
REQ-017 FSM states SHALL be IDLE, FETCH, WAIT, HOLD and DROP, with at most one outstanding memory request.
REQ-018 IDLE SHALL last exactly one cycle after reset release and then go to FETCH.
REQ-019 FETCH SHALL drive imem_req=1 and imem_addr=pc for one cycle, then go to WAIT.
REQ-020 WAIT on imem_valid SHALL latch inst=imem_rdata, inst_pc=pc and pc=pc+4 (mod 2^32), then go to HOLD.
REQ-021 HOLD SHALL hold inst_valid=1 with stable inst and inst_pc, and go to FETCH on inst_valid&inst_ready.
REQ-022 inst_valid SHALL be 1 only in HOLD, so sustained throughput is one instruction per 3+ cycles.
REQ-023 taken SHALL equal resolve_valid & (Jump | (BranchEq & Zero) | (BranchNeq & ~Zero)).
REQ-024 Jump target SHALL be {(resolve_pc+4)[31:28], resolve_inst[25:0], 2'b00}.
REQ-025 Branch target SHALL be resolve_pc + 4 + (sign-extended resolve_inst[15:0] << 2), 32-bit wrap.
REQ-026 Jump SHALL have priority if Jump and a branch flag are both set.
REQ-027 On taken, in any state except IDLE, pc SHALL load the target and inst_valid SHALL be 0 from the next cycle.
REQ-028 Redirect priority: taken SHALL override capture, handshake and FETCH issue in the same cycle.
REQ-029 Taken in WAIT with imem_valid=0 SHALL go to DROP.
REQ-030 Taken in FETCH (request issued) SHALL go to DROP.
REQ-031 Taken in WAIT with imem_valid=1 SHALL discard the response and go to FETCH.
REQ-032 Taken in HOLD SHALL discard inst and go to FETCH.
REQ-033 DROP SHALL discard the next imem_valid without updating inst/inst_pc and then go to FETCH.
REQ-034 A second taken during DROP SHALL update pc only; DROP remains until the stale response arrives.
REQ-035 resolve_valid with taken=0 SHALL have no effect.

Reset
REQ-036 Reset values SHALL be: state=IDLE, pc=RESET_PC, inst=0, inst_pc=0, inst_valid=0, imem_req=0, imem_addr=0.
REQ-037 Reset asserted mid-request SHALL abandon the request, and any later imem_valid in IDLE SHALL be ignored.

Structure
REQ-038 The FSM state encoding and the default value of RESET_PC SHALL be defined in the shared mips_pkg package.
REQ-039 The J opcode (6'b000010) and the instruction field positions SHALL be defined in mips_pkg.
REQ-040 Target computation SHALL be a combinational sub-module named branch_target_calc; the rest SHALL be flat.

Verification
REQ-041 Reset release, memory latency 1, inst_ready=1 -> imem_addr 0x0, 0x4, 0x8, with inst_pc matching each inst.
REQ-042 inst_ready=0 for 5 cycles in HOLD -> inst and inst_valid stable, and no imem_req issued.
REQ-043 resolve_pc=0x100, BranchEq=1, Zero=1, imm=0xFFFE -> next fetch address 0x0FC; with Zero=0 -> no redirect.
REQ-044 Jump=1, resolve_pc=0x3000_0010, resolve_inst[25:0]=0x0000040 -> next fetch address 0x3000_0100.
REQ-045 Taken in WAIT with a 3-cycle memory -> stale word never raises inst_valid, and next request goes to the target.
REQ-046 Reset asserted during WAIT, then a late imem_valid -> outputs stay at reset values and first fetch is RESET_PC.
